uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver: the receive-side counterpart of the existing `top_uart` transmit path. It samples an asynchronous `serial_rxd` line on the 12 MHz board clock and deframes 8N1 characters (8 data bits, LSB first, no parity, 1 stop bit). Each received byte goes into a one-entry holding register with a valid/ack handshake, so the 6502 system bus or a test top can consume it at its own pace. The block also reports framing errors and overruns.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per bit (12 MHz / 115200 baud, truncated); legal range 8..65535.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (integer division): count from the start-bit falling edge to the start-bit centre.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock, 12 MHz; all logic on the rising edge.
- `rst` input 1: synchronous active-high reset.
- `serial_rxd` input 1: asynchronous serial line; idles high.
- `rx_ack` input 1: consumer acknowledge; clears `rx_valid`.
- `rx_data` output 8: last accepted byte.
- `rx_valid` output 1: level; high while `rx_data` holds an unacknowledged byte.
- `rx_overrun` output 1: sticky; a byte was dropped because `rx_valid` was still high.
- `rx_frame_err` output 1: one-cycle pulse; stop bit was sampled low.
- `rx_busy` output 1: high whenever the state machine is not in IDLE.

## Operation
- Input synchroniser:
  - `serial_rxd` passes through 2 flops, producing `rxd_s`; both flops reset to 1.
  - All decisions below use `rxd_s` only.
- State machine (IDLE, START, DATA, STOP, BREAK); a bit counter `cnt` of width clog2(CLKS_PER_BIT) and a bit index `idx` of 3 bits:
  - IDLE: when `rxd_s`==0, go to START with `cnt`=0.
  - START: `cnt` increments each cycle. At `cnt`==HALF_BIT-1, sample `rxd_s`:
    - 0: go to DATA with `cnt`=0 and `idx`=0.
    - 1: glitch or false start; return to IDLE with no output.
  - DATA: at `cnt`==CLKS_PER_BIT-1, shift `rxd_s` into the shift register at bit `idx` (LSB first) and reset `cnt` to 0. After the sample with `idx`==7, go to STOP; otherwise increment `idx`.
  - STOP: at `cnt`==CLKS_PER_BIT-1, sample `rxd_s`:
    - 1: the frame is good; deliver it (see Holding register) and return to IDLE. Returning here, at mid-stop-bit, allows a back-to-back start bit to be caught.
    - 0: pulse `rx_frame_err` for 1 cycle, discard the byte, and go to BREAK.
  - BREAK: wait until `rxd_s`==1, then go to IDLE. A held-low line never produces a second error.
- Holding register, on delivery of a good frame:
  - If `rx_valid`==0, or `rx_ack`==1 in the same cycle: `rx_data` takes the new byte and `rx_valid` is 1.
  - Otherwise: the new byte is dropped, `rx_data` is unchanged, and `rx_overrun` is set to 1.
- Acknowledge:
  - `rx_ack` with no delivery in the same cycle clears `rx_valid` on the next edge and also clears `rx_overrun`.
  - `rx_ack` while `rx_valid`==0 has no effect.
  - Simultaneous delivery and ack: the new byte wins, `rx_valid` stays 1, and `rx_overrun` is cleared.
- `rx_busy` = (state != IDLE), registered alongside the state.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_overrun`=0, `rx_frame_err`=0, `rx_busy`=0, state IDLE, `cnt`=0, `idx`=0, synchroniser flops=1.
  - Reset asserted mid-frame aborts the frame on the next edge; nothing is delivered.
- Latency:
  - Falling edge on `serial_rxd` to IDLE leaving: 3 cycles (2 synchroniser cycles + 1 detect cycle).
  - Stop-bit sample to `rx_valid`/`rx_data` update, or to the `rx_frame_err` pulse: 1 cycle (registered).
  - Nominal falling edge to `rx_valid`: 3 + HALF_BIT + 9·CLKS_PER_BIT cycles (= 991 for the defaults).
- Sampling points fall at the bit centre ±1 cycle. Frames are received correctly for baud error up to ±3%.
- `rx_ack` takes effect on the edge where it is sampled high; it needs no pulse-width discipline beyond 1 cycle.

## Test plan
- Frame 0x55 at exactly 104 clk/bit, `rx_ack` low -> `rx_valid` rises 1 cycle after the stop sample, `rx_data`=0x55, `rx_busy` low afterwards, no error.
- Low glitch of 20 cycles on an idle line -> `rx_busy` high for under 60 cycles, then low; `rx_valid`, `rx_frame_err` and `rx_overrun` stay 0.
- Frame 0xA3 with the stop bit driven low, then the line held low for 3 bit times -> exactly one `rx_frame_err` pulse, `rx_valid` stays 0; after the line returns high, 0x3C is received correctly.
- Back-to-back 0x12 then 0x34 with no ack -> `rx_data`=0x12, `rx_overrun`=1. Assert `rx_ack` for 1 cycle -> `rx_valid`=0 and `rx_overrun`=0.
- 0x12 received, then `rx_ack` asserted exactly in the delivery cycle of 0x34 -> `rx_data`=0x34, `rx_valid`=1, `rx_overrun`=0.
- `rst` asserted during data bit 4 of 0xFF -> all outputs at reset values the next cycle, no delivery. A following 0x81 frame at 101 clk/bit (+3% baud) is received as 0x81.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry valid/ack holding register.
//   clk, rst           : clock and synchronous active-high reset
//   serial_rxd         : asynchronous serial line, idles high
//   rx_ack             : consumer acknowledge, clears rx_valid (and rx_overrun)
//   rx_data, rx_valid  : last accepted byte and its unacknowledged flag
//   rx_overrun         : sticky, a good frame was dropped while rx_valid was high
//   rx_frame_err       : one-cycle pulse when the stop bit is sampled low
//   rx_busy            : receiver is somewhere other than IDLE
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          sync1_q, sync2_q;
    logic          rxd_s;
    logic          deliver;

    assign rxd_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        deliver = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = rxd_s ? S_IDLE : S_START;
            end
            S_START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF_LAST) begin
                    // A start bit that is high again at its centre was a glitch
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxd_s;
                    idx_d          = idx_q + 3'd1;
                    state_d        = (idx_q == 3'd7) ? S_STOP : S_DATA;
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BIT_LAST) begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be seen
                    cnt_d   = '0;
                    deliver = rxd_s;
                    ferr_d  = ~rxd_s;
                    state_d = rxd_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: state_d = rxd_s ? S_IDLE : S_BREAK;
            default: state_d = S_IDLE;
        endcase
        // A delivery coinciding with an ack replaces the held byte
        data_d  = (deliver && (!valid_q || rx_ack)) ? shreg_q : data_q;
        valid_d = deliver ? 1'b1 : (rx_ack ? 1'b0 : valid_q);
        ovr_d   = rx_ack ? 1'b0 : ((deliver && valid_q) ? 1'b1 : ovr_q);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= serial_rxd;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a byte-level holding-register model.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_overrun, rx_frame_err, rx_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ferr_total = 0;
    int busy_total = 0;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;

    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;

    uart_rx dut (
        .clk(clk), .rst(rst), .serial_rxd(serial_rxd), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
        .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_frame_err) ferr_total <= ferr_total + 1;
        if (rx_busy) busy_total <= busy_total + 1;
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line is left at the stop-bit level when the frame ends
    task automatic send(input logic [7:0] b, input int cpb, input logic stop);
        serial_rxd = 1'b0;
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            serial_rxd = b[i];
            tick(cpb);
        end
        serial_rxd = stop;
        tick(cpb);
    endtask

    task automatic model_frame(input logic [7:0] b);
        if (!m_valid) begin
            m_data  = b;
            m_valid = 1'b1;
        end else m_ovr = 1'b1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"}, rx_data, m_data);
        check({tag, "_valid"}, rx_valid, m_valid);
        check({tag, "_ovr"}, rx_overrun, m_ovr);
    endtask

    initial begin
        int c0, b0, f0, cpb, gap;
        logic [7:0] b;
        tick(3);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_ovr", rx_overrun, 0);
        check("rst_ferr", rx_frame_err, 0);
        check("rst_busy", rx_busy, 0);
        rst = 1'b0;
        tick(5);

        c0 = cyc;
        send(8'h55, 104, 1'b1);
        model_frame(8'h55);
        check("lat_991", rise_cyc - c0, 991);
        check_model("t55");
        check("t55_busy", rx_busy, 0);
        check("t55_ferr", ferr_total, 0);
        pulse_ack();
        check("ack_valid", rx_valid, 0);

        b0 = busy_total;
        f0 = ferr_total;
        serial_rxd = 1'b0;
        tick(20);
        serial_rxd = 1'b1;
        tick(100);
        check("glitch_busy_range", ((busy_total - b0) > 0) && ((busy_total - b0) < 60), 1);
        check("glitch_busy_end", rx_busy, 0);
        check("glitch_ferr", ferr_total - f0, 0);
        check_model("glitch");

        f0 = ferr_total;
        send(8'hA3, 104, 1'b0);
        tick(312);
        check("brk_busy", rx_busy, 1);
        serial_rxd = 1'b1;
        tick(20);
        check("ferr_once", ferr_total - f0, 1);
        check("ferr_valid", rx_valid, 0);
        send(8'h3C, 104, 1'b1);
        model_frame(8'h3C);
        check_model("after_brk");
        pulse_ack();

        send(8'h12, 104, 1'b1);
        model_frame(8'h12);
        send(8'h34, 104, 1'b1);
        model_frame(8'h34);
        check_model("ovr");
        check("ovr_set", rx_overrun, 1);
        pulse_ack();
        check_model("ovr_ack");

        send(8'h12, 104, 1'b1);
        model_frame(8'h12);
        check_model("pre_sim");
        fork
            send(8'h34, 104, 1'b1);
            begin
                tick(990);
                rx_ack = 1'b1;
                tick(1);
                rx_ack = 1'b0;
            end
        join
        m_data  = 8'h34;
        m_valid = 1'b1;
        m_ovr   = 1'b0;
        check_model("sim_ack");
        pulse_ack();

        fork
            send(8'hFF, 104, 1'b1);
            begin
                tick(500);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                m_data = 8'h00;
                check_model("mid_rst");
                check("mid_rst_busy", rx_busy, 0);
                check("mid_rst_ferr", rx_frame_err, 0);
            end
        join
        tick(20);
        check_model("post_rst");
        send(8'h81, 101, 1'b1);
        tick(10);
        model_frame(8'h81);
        check_model("fast_81");
        pulse_ack();

        for (int n = 0; n < 12; n++) begin
            b   = 8'($urandom);
            cpb = $urandom_range(101, 107);
            gap = $urandom_range(0, 200);
            f0  = ferr_total;
            if ($urandom_range(0, 1) == 1) pulse_ack();
            tick(gap);
            send(b, cpb, 1'b1);
            model_frame(b);
            check_model($sformatf("rnd%0d", n));
            check($sformatf("rnd%0d_ferr", n), ferr_total - f0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
